// File: rtl/mem_io_responder_pkg.sv
// Shared constants, access classification and address decode for the
// CPU-side memory/IO responder.
package mem_io_responder_pkg;

  localparam int BYTE_WID = 8;
  localparam int ADDR_WID = 32;
  localparam int DEC_WID  = 18;

  localparam logic [1:0]         IO_SEL_BITS  = 2'b11;
  localparam logic [DEC_WID-1:0] IO_PORT_ADDR = 18'h30000;
  localparam logic [DEC_WID-1:0] IO_CLK_ADDR  = 18'h30004;

  typedef enum logic [2:0] {
    ACC_RAM,
    ACC_PORT,
    ACC_CLK0,
    ACC_CLK_HI,
    ACC_IO_OTHER
  } acc_e;

  // ACC_CLK_HI covers 0x30005..0x30007, the snapshot bytes.
  function automatic acc_e decode(input logic [DEC_WID-1:0] a);
    if (a[DEC_WID-1:DEC_WID-2] != IO_SEL_BITS) return ACC_RAM;
    if (a == IO_PORT_ADDR) return ACC_PORT;
    if (a == IO_CLK_ADDR) return ACC_CLK0;
    if (a[DEC_WID-1:2] == IO_CLK_ADDR[DEC_WID-1:2]) return ACC_CLK_HI;
    return ACC_IO_OTHER;
  endfunction

endpackage

// File: rtl/io_tx_fifo.sv
// Parameterised byte FIFO for UART TX: circular buffer plus count register.
// A push while full is accepted only when a pop happens in the same cycle.
module io_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WID   = 8,
  localparam int PTR_WID = $clog2(DEPTH),
  localparam int CNT_WID = PTR_WID + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [WID-1:0]     wdata,
  input  logic               pop,
  output logic [CNT_WID-1:0] count,
  output logic [WID-1:0]     head,
  output logic               empty,
  output logic               full
);

  logic [WID-1:0]     mem [DEPTH];
  logic [PTR_WID-1:0] wr_ptr, rd_ptr;
  logic               push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_WID'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; validity is tracked by count alone, which keeps
  // the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Target-side responder for the CPU byte bus: 128 KB RAM, UART RX/TX ports,
// coherent cycle-counter reads and the stop/terminator handshake.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WID  = 17,
  parameter int TX_FIFO_DEPTH = 16,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [ADDR_WID-1:0] cpu_a,
  input  logic                cpu_wr,
  input  logic [BYTE_WID-1:0] cpu_wdata,
  output logic [BYTE_WID-1:0] cpu_rdata,
  output logic                io_buffer_full,
  input  logic                rx_valid,
  input  logic [BYTE_WID-1:0] rx_data,
  output logic                rx_pop,
  output logic                tx_valid,
  output logic [BYTE_WID-1:0] tx_data,
  input  logic                tx_ready,
  output logic                program_done,
  output logic                tx_overflow
);

  localparam int CNT_WID = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [CNT_WID-1:0] FULL_THRESH = CNT_WID'(TX_FIFO_DEPTH - FULL_MARGIN);

  acc_e                acc;
  logic                unused_a_hi;
  logic [BYTE_WID-1:0] ram [2**RAM_ADDR_WID];
  logic [BYTE_WID-1:0] ram_q, io_q, io_rdata;
  logic                rd_ram_q;
  logic [31:0]         cyc_cnt, snap;
  logic                stop_seen, nul_pending;
  logic                port_wr, stop_wr, tx_pop, can_accept, nul_req;
  logic                fifo_push, fifo_empty, fifo_full;
  logic [BYTE_WID-1:0] fifo_wdata;
  logic [CNT_WID-1:0]  fifo_count, cnt_next;

  assign acc         = decode(cpu_a[DEC_WID-1:0]);
  assign unused_a_hi = ^cpu_a[ADDR_WID-1:DEC_WID];

  // After stop every I/O write is ignored, so port pushes and the pending
  // terminator can never compete for the same FIFO slot.
  assign port_wr    = cpu_wr && (acc == ACC_PORT) && !stop_seen && (cpu_wdata != '0);
  assign stop_wr    = cpu_wr && (acc == ACC_CLK0) && !stop_seen;
  assign tx_pop     = tx_valid && tx_ready;
  assign can_accept = !fifo_full || tx_pop;
  assign nul_req    = stop_wr || nul_pending;
  assign fifo_push  = (port_wr || nul_req) && can_accept;
  assign fifo_wdata = port_wr ? cpu_wdata : '0;

  // Gated by reset so the strobe drops the instant reset asserts.
  assign rx_pop = rst_in && !cpu_wr && (acc == ACC_PORT) && rx_valid;

  assign cpu_rdata = rd_ram_q ? ram_q : io_q;
  assign tx_valid  = !fifo_empty;

  io_tx_fifo #(
    .DEPTH (TX_FIFO_DEPTH),
    .WID   (BYTE_WID)
  ) u_tx_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (tx_pop),
    .count (fifo_count),
    .head  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch is never inferred.
  always_comb begin
    io_rdata = '0;
    if (!cpu_wr) begin
      case (acc)
        ACC_PORT:   io_rdata = rx_valid ? rx_data : '0;
        ACC_CLK0:   io_rdata = cyc_cnt[BYTE_WID-1:0];
        ACC_CLK_HI: io_rdata = snap[{cpu_a[1:0], 3'b000} +: BYTE_WID];
        default:    io_rdata = '0;
      endcase
    end
  end

  always_comb begin
    cnt_next = fifo_count;
    if (fifo_push && !tx_pop)      cnt_next = fifo_count + 1'b1;
    else if (!fifo_push && tx_pop) cnt_next = fifo_count - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (cpu_wr && (acc == ACC_RAM)) ram[cpu_a[RAM_ADDR_WID-1:0]] <= cpu_wdata;
    ram_q <= ram[cpu_a[RAM_ADDR_WID-1:0]];
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ram_q       <= 1'b0;
      io_q           <= '0;
      cyc_cnt        <= '0;
      snap           <= '0;
      stop_seen      <= 1'b0;
      nul_pending    <= 1'b0;
      io_buffer_full <= 1'b0;
      program_done   <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      rd_ram_q       <= (acc == ACC_RAM);
      io_q           <= io_rdata;
      cyc_cnt        <= cyc_cnt + 32'd1;
      io_buffer_full <= (cnt_next >= FULL_THRESH);
      if (!cpu_wr && (acc == ACC_CLK0)) snap <= cyc_cnt;
      if (port_wr && !can_accept) tx_overflow <= 1'b1;
      if (stop_wr) stop_seen <= 1'b1;
      if (nul_req) nul_pending <= !can_accept;
      // Zero bytes never enter the FIFO except the terminator, and nothing
      // follows it, so popping a 0x00 as the last entry marks the drain.
      if (stop_seen && !nul_pending && tx_pop && (tx_data == '0) && (fifo_count == CNT_WID'(1)))
        program_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: stimulus queues expected read data and
// TX bytes, a negedge monitor compares whenever the DUT presents them.
module tb_mem_io_responder;

  logic        clk_in, rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_pop, tx_valid, tx_ready, program_done, tx_overflow;
  logic [7:0]  tx_data;

  int          checks, errors;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  bit          rd_capt, pending_chk, done_chk_next;
  int          edges;
  logic [31:0] target;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cpu_a          (cpu_a),
    .cpu_wr         (cpu_wr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .io_buffer_full (io_buffer_full),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_pop         (rx_pop),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .program_done   (program_done),
    .tx_overflow    (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input bit chk, input logic [7:0] exp);
    cpu_a       = a;
    cpu_wr      = wr;
    cpu_wdata   = d;
    pending_chk = chk;
    if (chk) rd_q.push_back(exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    rd_capt = pending_chk;
    if (rst_in) edges++;
    #1;
  endtask

  task automatic cycle(input logic [31:0] a, input logic wr, input logic [7:0] d,
                       input bit chk, input logic [7:0] exp);
    drive(a, wr, d, chk, exp);
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(32'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // Monitor: read data the cycle after a checked read, TX bytes as they pop.
  always @(negedge clk_in) begin
    if (done_chk_next) begin
      check("program_done_after_nul_pop", {31'b0, program_done}, 32'd1);
      done_chk_next = 1'b0;
    end
    if (rd_capt) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_scoreboard: read captured with no expected value");
      end else begin
        check("cpu_rdata", {24'b0, cpu_rdata}, {24'b0, rd_q.pop_front()});
      end
    end
    if (tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_scoreboard: unexpected byte 0x%0h", tx_data);
      end else begin
        logic [7:0] exp;
        exp = tx_q.pop_front();
        check("tx_data", {24'b0, tx_data}, {24'b0, exp});
        if (exp == 8'h00) begin
          check("program_done_before_nul_pop", {31'b0, program_done}, 32'd0);
          done_chk_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; edges = 0;
    rd_capt = 0; pending_chk = 0; done_chk_next = 0;
    rst_in = 1'b0; cpu_a = '0; cpu_wr = 1'b0; cpu_wdata = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_cpu_rdata", {24'b0, cpu_rdata}, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'b0, tx_data}, 32'h0);
    check("rst_io_buffer_full", {31'b0, io_buffer_full}, 32'h0);
    check("rst_program_done", {31'b0, program_done}, 32'h0);
    check("rst_tx_overflow", {31'b0, tx_overflow}, 32'h0);
    check("rst_rx_pop", {31'b0, rx_pop}, 32'h0);
    rst_in = 1'b1;
    edges  = 0;

    // RAM round trip
    cycle(32'h0000_0010, 1'b1, 8'hA5, 1'b0, 8'h00);
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
    cycle(32'h0001_FFFF, 1'b1, 8'h3C, 1'b0, 8'h00);
    cycle(32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'h3C);

    // Zero filter
    cycle(32'h0003_0000, 1'b1, 8'h48, 1'b0, 8'h00); tx_q.push_back(8'h48);
    check("zf_tx_valid", {31'b0, tx_valid}, 32'd1);
    cycle(32'h0003_0000, 1'b1, 8'h00, 1'b0, 8'h00);
    cycle(32'h0003_0000, 1'b1, 8'h69, 1'b0, 8'h00); tx_q.push_back(8'h69);
    tx_ready = 1'b1;
    idle(4);
    check("zf_drained", {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Counter coherence: first counter value with low byte 0xFF
    target = {edges[31:8], 8'hFF};
    while (edges != int'(target)) idle(1);
    cycle(32'h0003_0004, 1'b0, 8'h00, 1'b1, target[7:0]);
    cycle(32'h0003_0005, 1'b0, 8'h00, 1'b1, target[15:8]);
    cycle(32'h0003_0006, 1'b0, 8'h00, 1'b1, target[23:16]);
    cycle(32'h0003_0007, 1'b0, 8'h00, 1'b1, target[31:24]);
    cycle(32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00);

    // Back-pressure
    for (int i = 0; i < 16; i++) begin
      cycle(32'h0003_0000, 1'b1, 8'(8'h10 + i), 1'b0, 8'h00);
      tx_q.push_back(8'(8'h10 + i));
      if (i == 12) check("bp_ibf_after_13", {31'b0, io_buffer_full}, 32'd0);
      if (i == 13) check("bp_ibf_after_14", {31'b0, io_buffer_full}, 32'd1);
    end
    check("bp_no_overflow_yet", {31'b0, tx_overflow}, 32'd0);
    cycle(32'h0003_0000, 1'b1, 8'h7F, 1'b0, 8'h00);
    check("bp_overflow", {31'b0, tx_overflow}, 32'd1);

    // Stop with a full FIFO, then a write that must be ignored
    cycle(32'h0003_0004, 1'b1, 8'h55, 1'b0, 8'h00); tx_q.push_back(8'h00);
    cycle(32'h0003_0000, 1'b1, 8'h41, 1'b0, 8'h00);
    check("stop_not_done", {31'b0, program_done}, 32'd0);
    tx_ready = 1'b1;
    for (int i = 0; i < 40 && !program_done; i++) idle(1);
    idle(1);
    check("stop_program_done", {31'b0, program_done}, 32'd1);
    check("stop_tx_empty", {31'b0, tx_valid}, 32'd0);
    check("stop_ibf_clear", {31'b0, io_buffer_full}, 32'd0);
    check("stop_tx_q_left", tx_q.size(), 32'd0);

    // RX pop
    rx_valid = 1'b1; rx_data = 8'h31;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h31);
    #1 check("rx_pop_high", {31'b0, rx_pop}, 32'd1);
    tick();
    rx_valid = 1'b0;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h00);
    #1 check("rx_pop_low", {31'b0, rx_pop}, 32'd0);
    tick();
    cycle(32'h0003_0010, 1'b0, 8'h00, 1'b1, 8'h00);

    // Async reset mid-cycle with live outputs
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b1, 8'hA5);
    cycle(32'h0000_0010, 1'b0, 8'h00, 1'b0, 8'h00);
    rx_valid = 1'b1;
    drive(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h00);
    #2 rst_in = 1'b0;
    #1;
    check("arst_cpu_rdata", {24'b0, cpu_rdata}, 32'h0);
    check("arst_rx_pop", {31'b0, rx_pop}, 32'h0);
    check("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("arst_tx_data", {24'b0, tx_data}, 32'h0);
    check("arst_io_buffer_full", {31'b0, io_buffer_full}, 32'h0);
    check("arst_program_done", {31'b0, program_done}, 32'h0);
    check("arst_tx_overflow", {31'b0, tx_overflow}, 32'h0);
    rx_valid = 1'b0;
    tick();
    check("rd_q_left", rd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
